// File: rtl/piso_pkg.sv
// piso_pkg: encodings shared by the piso transmitter and the sipo-style receiver.
//   state_t    FSM state encoding (ST_IDLE/ST_START/ST_DATA/ST_PARITY/ST_STOP)
//   LINE_IDLE  level of the serial line between frames
//   START_BIT  level of the start bit
//   STOP_BIT   level of the stop bit
package piso_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// bit_timer: bit-period timer, counts 0..CLKS_PER_BIT-1 and wraps.
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   clr   in   synchronous clear, holds the count at 0
//   tick  out  high on the last cycle of each bit period
module bit_timer
  import piso_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// Frame on so: start (0), WIDTH data bits, optional even parity, stop (1).
// Optional parity bit is built in when PISO_PARITY_EN is defined.
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   load     in   start request, accepted only in IDLE
//   pi       in   parallel word, captured when load is accepted
//   so       out  serial line, idles high
//   busy     out  high while a frame is on the line
//   done     out  one-cycle pulse on return to IDLE after the stop bit
//   bit_idx  out  index of the data bit on so, 0 outside DATA
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | line high, waiting for load
// ST_START  | start bit on the line
// ST_DATA   | data bits, bit_idx 0..WIDTH-1
// ST_PARITY | even parity of the captured word (optional)
// ST_STOP   | stop bit; done pulses on leaving
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 100000,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pi,
  output logic             so,
  output logic             busy,
  output logic             done,
  output logic [4:0]       bit_idx
);

  localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic [4:0]       bit_cnt;
  logic             tick;
  logic             timer_clr;
  logic             done_q;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  // Holding the timer clear in IDLE makes START begin at count 0.
  assign timer_clr = (state == ST_IDLE);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    so       = LINE_IDLE;
    busy     = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (load) state_nx = ST_START;
      end
      ST_START: begin
        so = START_BIT;
        if (tick) state_nx = ST_DATA;
      end
      ST_DATA: begin
        so = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
        if (tick && (bit_cnt == LAST_BIT)) begin
`ifdef PISO_PARITY_EN
          state_nx = ST_PARITY;
`else
          state_nx = ST_STOP;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        so = parity_q;
        if (tick) state_nx = ST_STOP;
      end
`endif
      ST_STOP: begin
        so = STOP_BIT;
        if (tick) state_nx = ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= (state == ST_STOP) && tick;
      if ((state == ST_IDLE) && load) begin
        shreg   <= pi;
        bit_cnt <= '0;
`ifdef PISO_PARITY_EN
        parity_q <= ^pi;
`endif
      end else if ((state == ST_DATA) && tick) begin
        // The bit on so is always at the outgoing end, so each period shifts one place.
        shreg   <= (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
        bit_cnt <= (bit_cnt == LAST_BIT) ? 5'd0 : bit_cnt + 5'd1;
      end
    end
  end

  assign done    = done_q;
  assign bit_idx = (state == ST_DATA) ? bit_cnt : 5'd0;

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int FL = 28;
`else
  localparam int FL = 24;
`endif

  typedef struct {
    logic [3:0] pi;
    logic [3:0] exp_msb;  // data bits in send order, bit 3 sent first
    logic [3:0] exp_lsb;
    logic       exp_par;
  } vec_t;

  typedef struct {
    logic       so_m;
    logic       so_l;
    logic       busy;
    logic       done;
    logic [4:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] pi;
  logic       so_m, busy_m, done_m;
  logic       so_l, busy_l, done_l;
  logic [4:0] idx_m, idx_l;
  logic       mon_en;
  logic       finished = 1'b0;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[8];
  exp_t sb[$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .load(load), .pi(pi),
    .so(so_m), .busy(busy_m), .done(done_m), .bit_idx(idx_m)
  );

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .load(load), .pi(pi),
    .so(so_l), .busy(busy_l), .done(done_l), .bit_idx(idx_l)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (sb.size() != 0) e = sb.pop_front();
      else e = '{so_m: 1'b1, so_l: 1'b1, busy: 1'b0, done: 1'b0, idx: 5'd0};
      checks++;
      if (so_m !== e.so_m || so_l !== e.so_l || busy_m !== e.busy || busy_l !== e.busy ||
          done_m !== e.done || done_l !== e.done || idx_m !== e.idx || idx_l !== e.idx) begin
        failures++;
        $display("FAIL stream t=%0t got/exp so_msb=%b/%b so_lsb=%b/%b busy=%b%b/%b done=%b%b/%b idx=%0d,%0d/%0d",
                 $time, so_m, e.so_m, so_l, e.so_l, busy_m, busy_l, e.busy,
                 done_m, done_l, e.done, idx_m, idx_l, e.idx);
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    if (!finished) begin
      failures++;
      $display("FAIL timeout t=%0t test sequence did not complete", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic check_reset(input string tag);
    checks++;
    if (so_m !== 1'b1 || so_l !== 1'b1 || busy_m !== 1'b0 || busy_l !== 1'b0 ||
        done_m !== 1'b0 || done_l !== 1'b0 || idx_m !== 5'd0 || idx_l !== 5'd0) begin
      failures++;
      $display("FAIL reset(%s) t=%0t so=%b%b busy=%b%b done=%b%b idx=%0d,%0d",
               tag, $time, so_m, so_l, busy_m, busy_l, done_m, done_l, idx_m, idx_l);
    end
  endtask

  task automatic push_n(input logic sm, input logic sl, input logic b, input logic d,
                        input logic [4:0] ix, input int n);
    for (int k = 0; k < n; k++) sb.push_back('{so_m: sm, so_l: sl, busy: b, done: d, idx: ix});
  endtask

  task automatic push_frame(input int vi);
    push_n(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 4);
    for (int b = 0; b < 4; b++)
      push_n(vecs[vi].exp_msb[3-b], vecs[vi].exp_lsb[3-b], 1'b1, 1'b0, 5'(b), 4);
`ifdef PISO_PARITY_EN
    push_n(vecs[vi].exp_par, vecs[vi].exp_par, 1'b1, 1'b0, 5'd0, 4);
`endif
    push_n(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 4);
    push_n(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the accepting edge.
  task automatic start_frame(input int vi);
    load = 1'b1;
    pi   = vecs[vi].pi;
    wait_cycles(1);
    load = 1'b0;
    pi   = 4'($urandom_range(0, 15));
    push_frame(vi);
  endtask

  initial begin
    vecs[0] = '{4'b1011, 4'b1011, 4'b1101, 1'b1};
    vecs[1] = '{4'b0111, 4'b0111, 4'b1110, 1'b1};
    vecs[2] = '{4'b0110, 4'b0110, 4'b0110, 1'b0};
    vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[4] = '{4'b1111, 4'b1111, 4'b1111, 1'b0};
    vecs[5] = '{4'b1000, 4'b1000, 4'b0001, 1'b1};
    vecs[6] = '{4'b0001, 4'b0001, 4'b1000, 1'b1};
    vecs[7] = '{4'b1100, 4'b1100, 4'b0011, 1'b0};

    rst    = 1'b1;
    load   = 1'b0;
    pi     = 4'b0000;
    mon_en = 1'b0;
    wait_cycles(1);
    mon_en = 1'b1;
    wait_cycles(1);
    check_reset("power-on");
    rst = 1'b0;
    wait_cycles(1);

    for (int i = 0; i < 8; i++) begin
      start_frame(i);
      wait_cycles(FL + 2);
    end

    // load during a frame is ignored; load on the done cycle starts the next frame
    start_frame(0);
    wait_cycles(7);
    load = 1'b1;
    pi   = 4'b0000;
    wait_cycles(1);
    load = 1'b0;
    wait_cycles(FL - 8);
    start_frame(1);
    wait_cycles(FL + 2);

    // load held high: only the first idle cycle starts a frame
    load = 1'b1;
    pi   = vecs[2].pi;
    wait_cycles(1);
    push_frame(2);
    pi = 4'b1001;
    wait_cycles(2);
    load = 1'b0;
    wait_cycles(FL + 2);

    // reset during DATA bit 2 aborts the frame without done
    start_frame(5);
    wait_cycles(13);
    rst = 1'b1;
    wait_cycles(1);
    sb.delete();
    check_reset("mid-frame");
    rst = 1'b0;
    wait_cycles(3);
    start_frame(6);
    wait_cycles(FL + 2);

    start_frame(7);
    wait_cycles(FL + 3);

    mon_en = 1'b0;
    finished = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
